// File: rtl/risc_test_sequencer.sv
// Host-side test sequencer for the single-cycle RISC core. It loads IR/DM images through the ext_* port,
// runs the core under a cycle timeout, and then streams a DM window back to the host.
module risc_test_sequencer #(
  parameter int IR_DEPTH = 32,
  parameter int DM_DEPTH = 256,
  parameter int TIMEOUT  = 4096,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        ir_count,
  input  logic [8:0]        dm_count,
  input  logic [7:0]        dm_base,
  input  logic [8:0]        dump_count,
  input  logic [7:0]        dump_base,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ext_IR_we,
  output logic              ext_DM_we,
  output logic [7:0]        ext_addr,
  output logic [DATA_W-1:0] ext_data,
  output logic              test_normal,
  output logic              cpu_reset_n,
  input  logic              cpu_done,
  input  logic [DATA_W-1:0] mem_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_IR, S_LOAD_DM, S_RUN, S_DUMP_ADDR, S_DUMP_WAIT
  } state_e;

  localparam logic [8:0]  IR_MAX   = 9'(IR_DEPTH);
  localparam logic [8:0]  DM_MAX   = 9'(DM_DEPTH);
  localparam logic [15:0] RUN_LAST = 16'(TIMEOUT - 1);

  state_e state_q, state_d;
  logic [8:0] idx_q, idx_d;
  logic [8:0] ir_cnt_q, ir_cnt_d, dm_cnt_q, dm_cnt_d, dump_cnt_q, dump_cnt_d;
  logic [7:0] dm_base_q, dm_base_d, dump_base_q, dump_base_d;
  logic in_ready_q, in_ready_d, ext_ir_we_q, ext_ir_we_d, ext_dm_we_q, ext_dm_we_d;
  logic [7:0] ext_addr_q, ext_addr_d;
  logic [DATA_W-1:0] ext_data_q, ext_data_d, out_data_q, out_data_d;
  logic test_normal_q, test_normal_d, cpu_reset_n_q, cpu_reset_n_d;
  logic out_valid_q, out_valid_d, busy_q, busy_d, timeout_err_q, timeout_err_d;
  logic [15:0] run_cycles_q, run_cycles_d;

  logic [8:0] ir_req, dm_req, dump_req;
  logic       accept, last_load, last_dump, run_exit;

  always_comb begin
    ir_req    = ({3'b000, ir_count} > IR_MAX) ? IR_MAX : {3'b000, ir_count};
    dm_req    = (dm_count > DM_MAX) ? DM_MAX : dm_count;
    dump_req  = (dump_count > DM_MAX) ? DM_MAX : dump_count;
    accept    = in_valid & in_ready_q;
    last_load = (idx_q + 9'd1) == ((state_q == S_LOAD_IR) ? ir_cnt_q : dm_cnt_q);
    last_dump = (idx_q + 9'd1) == dump_cnt_q;
    // Only cycles after the core is out of reset can end the run.
    run_exit  = cpu_reset_n_q & (cpu_done | (run_cycles_q == RUN_LAST));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      ir_cnt_q      <= '0;
      dm_cnt_q      <= '0;
      dump_cnt_q    <= '0;
      dm_base_q     <= '0;
      dump_base_q   <= '0;
      in_ready_q    <= 1'b0;
      ext_ir_we_q   <= 1'b0;
      ext_dm_we_q   <= 1'b0;
      ext_addr_q    <= '0;
      ext_data_q    <= '0;
      test_normal_q <= 1'b1;
      cpu_reset_n_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      run_cycles_q  <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ir_cnt_q      <= ir_cnt_d;
      dm_cnt_q      <= dm_cnt_d;
      dump_cnt_q    <= dump_cnt_d;
      dm_base_q     <= dm_base_d;
      dump_base_q   <= dump_base_d;
      in_ready_q    <= in_ready_d;
      ext_ir_we_q   <= ext_ir_we_d;
      ext_dm_we_q   <= ext_dm_we_d;
      ext_addr_q    <= ext_addr_d;
      ext_data_q    <= ext_data_d;
      test_normal_q <= test_normal_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      run_cycles_q  <= run_cycles_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ir_req != 9'd0)      state_d = S_LOAD_IR;
          else if (dm_req != 9'd0) state_d = S_LOAD_DM;
          else                     state_d = S_RUN;
        end
      end
      S_LOAD_IR:   if (accept && last_load) state_d = (dm_cnt_q != 9'd0) ? S_LOAD_DM : S_RUN;
      S_LOAD_DM:   if (accept && last_load) state_d = S_RUN;
      S_RUN:       if (run_exit) state_d = (dump_cnt_q != 9'd0) ? S_DUMP_ADDR : S_IDLE;
      S_DUMP_ADDR: state_d = S_DUMP_WAIT;
      S_DUMP_WAIT: if (out_ready) state_d = last_dump ? S_IDLE : S_DUMP_ADDR;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d         = idx_q;
    ir_cnt_d      = ir_cnt_q;
    dm_cnt_d      = dm_cnt_q;
    dump_cnt_d    = dump_cnt_q;
    dm_base_d     = dm_base_q;
    dump_base_d   = dump_base_q;
    ext_ir_we_d   = 1'b0;
    ext_dm_we_d   = 1'b0;
    ext_addr_d    = ext_addr_q;
    ext_data_d    = ext_data_q;
    test_normal_d = test_normal_q;
    cpu_reset_n_d = cpu_reset_n_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    timeout_err_d = timeout_err_q;
    run_cycles_d  = run_cycles_q;
    in_ready_d    = (state_d == S_LOAD_IR) || (state_d == S_LOAD_DM);
    busy_d        = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ir_cnt_d      = ir_req;
          dm_cnt_d      = dm_req;
          dump_cnt_d    = dump_req;
          dm_base_d     = dm_base;
          dump_base_d   = dump_base;
          idx_d         = '0;
          timeout_err_d = 1'b0;
          run_cycles_d  = '0;
        end
      end
      S_LOAD_IR: begin
        if (accept) begin
          ext_ir_we_d = 1'b1;
          ext_addr_d  = idx_q[7:0];
          ext_data_d  = in_data;
          idx_d       = last_load ? 9'd0 : idx_q + 9'd1;
        end
      end
      S_LOAD_DM: begin
        if (accept) begin
          ext_dm_we_d = 1'b1;
          ext_addr_d  = dm_base_q + idx_q[7:0];
          ext_data_d  = in_data;
          idx_d       = last_load ? 9'd0 : idx_q + 9'd1;
        end
      end
      S_RUN: begin
        if (!cpu_reset_n_q) begin
          cpu_reset_n_d = 1'b1;
        end else begin
          if (!cpu_done && run_cycles_q != 16'hFFFF) run_cycles_d = run_cycles_q + 16'd1;
          if (run_exit) begin
            test_normal_d = 1'b1;
            cpu_reset_n_d = 1'b0;
            timeout_err_d = ~cpu_done;
            idx_d         = '0;
            ext_addr_d    = dump_base_q;
          end
        end
      end
      S_DUMP_ADDR: begin
        out_data_d  = mem_out;
        out_valid_d = 1'b1;
      end
      S_DUMP_WAIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          idx_d       = last_dump ? 9'd0 : idx_q + 9'd1;
          ext_addr_d  = dump_base_q + idx_q[7:0] + 8'd1;
        end
      end
      default: ;
    endcase
    // Entering RUN holds the core in reset for one cycle with test mode already released.
    if (state_q != S_RUN && state_d == S_RUN) begin
      test_normal_d = 1'b0;
      cpu_reset_n_d = 1'b0;
    end
  end

  assign in_ready    = in_ready_q;
  assign ext_IR_we   = ext_ir_we_q;
  assign ext_DM_we   = ext_dm_we_q;
  assign ext_addr    = ext_addr_q;
  assign ext_data    = ext_data_q;
  assign test_normal = test_normal_q;
  assign cpu_reset_n = cpu_reset_n_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_risc_test_sequencer.sv
// Scoreboard bench for risc_test_sequencer: a behavioural data memory stands in for the core,
// and expected ext writes and dump words are queued as stimulus is driven.
module tb_risc_test_sequencer;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, cpu_done, out_ready;
  logic [5:0]  ir_count;
  logic [8:0]  dm_count, dump_count;
  logic [7:0]  dm_base, dump_base;
  logic [15:0] in_data, mem_out, ext_data, out_data;
  logic        in_ready, ext_IR_we, ext_DM_we, test_normal, cpu_reset_n;
  logic        out_valid, busy, timeout_err;
  logic [7:0]  ext_addr;
  logic [15:0] run_cycles;

  typedef struct packed {
    logic        is_dm;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_dump[$];
  logic [15:0] core_dm [256];
  logic [15:0] ref_dm  [256];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  risc_test_sequencer #(.IR_DEPTH(32), .DM_DEPTH(256), .TIMEOUT(TMO), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .ir_count(ir_count), .dm_count(dm_count),
    .dm_base(dm_base), .dump_count(dump_count), .dump_base(dump_base), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .ext_IR_we(ext_IR_we), .ext_DM_we(ext_DM_we),
    .ext_addr(ext_addr), .ext_data(ext_data), .test_normal(test_normal),
    .cpu_reset_n(cpu_reset_n), .cpu_done(cpu_done), .mem_out(mem_out), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy), .timeout_err(timeout_err),
    .run_cycles(run_cycles)
  );

  // Core data memory: written through the test port, read combinationally at ext_addr.
  always @(posedge clk) if (ext_DM_we === 1'b1) core_dm[ext_addr] <= ext_data;
  assign mem_out = core_dm[ext_addr];

  always @(negedge clk) begin : wr_monitor
    wr_t e;
    if (ext_IR_we === 1'b1 || ext_DM_we === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write ir_we=%b dm_we=%b addr=%h data=%h, none expected",
                 ext_IR_we, ext_DM_we, ext_addr, ext_data);
      end else begin
        e = exp_wr.pop_front();
        if (ext_IR_we === e.is_dm || ext_DM_we !== e.is_dm || ext_addr !== e.addr || ext_data !== e.data) begin
          errors++;
          $display("FAIL ext_write got ir_we=%b dm_we=%b addr=%h data=%h want dm=%b addr=%h data=%h",
                   ext_IR_we, ext_DM_we, ext_addr, ext_data, e.is_dm, e.addr, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin : dump_monitor
    logic [15:0] d;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_dump.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dump out_data=%h, none expected", out_data);
      end else begin
        d = exp_dump.pop_front();
        if (out_data !== d) begin
          errors++;
          $display("FAIL dump_word got=%h want=%h", out_data, d);
        end
      end
    end
  end

  task automatic test_reset(input string tag);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cpu_done = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, in_ready, ext_IR_we, ext_DM_we, test_normal, cpu_reset_n, out_valid, timeout_err} !== 8'b0000_1000) begin
      errors++;
      $display("FAIL %s_ctrl got busy,rdy,irwe,dmwe,tn,rstn,ov,to=%b want 00001000", tag,
               {busy, in_ready, ext_IR_we, ext_DM_we, test_normal, cpu_reset_n, out_valid, timeout_err});
    end
    checks++;
    if (ext_addr !== 8'h00 || ext_data !== 16'h0000) begin
      errors++;
      $display("FAIL %s_ext got addr=%h data=%h want 00 0000", tag, ext_addr, ext_data);
    end
    checks++;
    if (out_data !== 16'h0000 || run_cycles !== 16'h0000) begin
      errors++;
      $display("FAIL %s_out got out_data=%h run_cycles=%0d want 0 0", tag, out_data, run_cycles);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_ignores;
    in_valid = 1'b1; in_data = 16'hDEAD;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({in_ready, busy, ext_IR_we, ext_DM_we} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_ignore got rdy,busy,irwe,dmwe=%b want 0000", {in_ready, busy, ext_IR_we, ext_DM_we});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] irc, input logic [8:0] dmc, input logic [7:0] dmb,
                          input logic [8:0] dpc, input logic [7:0] dpb);
    ir_count = irc; dm_count = dmc; dm_base = dmb; dump_count = dpc; dump_base = dpb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the inputs: the sequencer must work from the values latched at start.
    ir_count = 6'h3F; dm_count = 9'h1FF; dm_base = 8'h55; dump_count = 9'h1FF; dump_base = 8'hAA;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy got=%b want=1", busy);
    end
  endtask

  task automatic load_words(input int n, input bit is_dm, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      logic [15:0] d;
      logic [7:0]  a;
      int          w;
      d = 16'($urandom);
      a = base + 8'(i);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_valid = 1'b1; in_data = d;
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready word=%0d got in_ready=%b want 1", i, in_ready);
        in_valid = 1'b0;
        return;
      end
      exp_wr.push_back({is_dm, a, d});
      if (is_dm) ref_dm[a] = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic run_core(input int done_after, input bit expect_timeout, input bit expect_dump);
    int w, held, cyc, exp_rc;
    w = 0; held = 0;
    while (cpu_reset_n !== 1'b1 && w < 40) begin
      @(negedge clk);
      if (test_normal === 1'b0 && cpu_reset_n === 1'b0) held++;
      w++;
    end
    checks++;
    if (cpu_reset_n !== 1'b1 || held != 1 || test_normal !== 1'b0) begin
      errors++;
      $display("FAIL run_release got rstn=%b held=%0d tn=%b want 1 1 0", cpu_reset_n, held, test_normal);
    end
    if (expect_timeout) begin
      cyc = 1; w = 0;
      while (w < 100) begin
        @(negedge clk); w++;
        if (cpu_reset_n !== 1'b1) break;
        cyc++;
      end
      checks++;
      if (cyc != TMO) begin
        errors++;
        $display("FAIL run_length got=%0d want=%0d", cyc, TMO);
      end
      exp_rc = TMO;
    end else begin
      repeat (done_after) @(posedge clk);
      #1 cpu_done = 1'b1;
      w = 0;
      while (cpu_reset_n === 1'b1 && w < 10) begin @(negedge clk); w++; end
      checks++;
      if (cpu_reset_n !== 1'b0) begin
        errors++;
        $display("FAIL done_exit got rstn=%b want 0", cpu_reset_n);
      end
      exp_rc = done_after;
    end
    checks++;
    if (run_cycles !== 16'(exp_rc) || timeout_err !== expect_timeout) begin
      errors++;
      $display("FAIL run_result got cycles=%0d to=%b want %0d %b", run_cycles, timeout_err, exp_rc, expect_timeout);
    end
    checks++;
    if (test_normal !== 1'b1 || busy !== expect_dump) begin
      errors++;
      $display("FAIL run_exit_state got tn=%b busy=%b want 1 %b", test_normal, busy, expect_dump);
    end
    @(posedge clk); #1;
    cpu_done = 1'b0;
  endtask

  task automatic dump_words(input int n, input logic [7:0] base, input int stall);
    int w;
    for (int i = 0; i < n; i++) exp_dump.push_back(ref_dm[base + 8'(i)]);
    out_ready = 1'b0;
    if (stall > 0) begin
      w = 0;
      while (out_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
      repeat (stall) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== ref_dm[base]) begin
          errors++;
          $display("FAIL dump_hold got ov=%b data=%h want 1 %h", out_valid, out_data, ref_dm[base]);
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    w = 0;
    while (busy !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    checks++;
    if (busy !== 1'b0 || exp_dump.size() != 0 || cpu_reset_n !== 1'b0) begin
      errors++;
      $display("FAIL dump_end got busy=%b left=%0d rstn=%b want 0 0 0", busy, exp_dump.size(), cpu_reset_n);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_load_ir;
    do_start(6'd3, 9'd0, 8'h00, 9'd0, 8'h00);
    load_words(3, 1'b0, 8'h00);
    run_core(3, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ir_idle got rdy=%b busy=%b want 0 0", in_ready, busy);
    end
  endtask

  task automatic test_load_dm_wrap;
    do_start(6'd0, 9'd3, 8'hFE, 9'd0, 8'h00);
    load_words(3, 1'b1, 8'hFE);
    run_core(2, 1'b0, 1'b0);
  endtask

  task automatic test_run_done;
    do_start(6'd2, 9'd0, 8'h00, 9'd0, 8'h00);
    load_words(2, 1'b0, 8'h00);
    run_core(10, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    do_start(6'd1, 9'd0, 8'h00, 9'd2, 8'hFE);
    load_words(1, 1'b0, 8'h00);
    run_core(0, 1'b1, 1'b1);
    dump_words(2, 8'hFE, 0);
  endtask

  task automatic test_dump_stall;
    do_start(6'd0, 9'd2, 8'h04, 9'd2, 8'h04);
    load_words(2, 1'b1, 8'h04);
    run_core(1, 1'b0, 1'b1);
    dump_words(2, 8'h04, 5);
  endtask

  task automatic test_ir_clamp;
    do_start(6'd40, 9'd0, 8'h00, 9'd0, 8'h00);
    load_words(32, 1'b0, 8'h00);
    checks++;
    if (in_ready !== 1'b0 || test_normal !== 1'b0) begin
      errors++;
      $display("FAIL ir_clamp got rdy=%b tn=%b want 0 0", in_ready, test_normal);
    end
    run_core(2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_load;
    do_start(6'd0, 9'd4, 8'h40, 9'd0, 8'h00);
    load_words(2, 1'b1, 8'h40);
    test_reset("mid_load");
    do_start(6'd1, 9'd0, 8'h00, 9'd1, 8'h04);
    load_words(1, 1'b0, 8'h00);
    run_core(2, 1'b0, 1'b1);
    dump_words(1, 8'h04, 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; cpu_done = 1'b0; out_ready = 1'b0;
    ir_count = '0; dm_count = '0; dm_base = '0; dump_count = '0; dump_base = '0;
    test_reset("reset");
    test_idle_ignores();
    test_load_ir();
    test_load_dm_wrap();
    test_run_done();
    test_timeout();
    test_dump_stall();
    test_ir_clamp();
    test_reset_mid_load();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_wr.size() != 0 || exp_dump.size() != 0) begin
      errors++;
      $display("FAIL leftover got writes=%0d dumps=%0d want 0 0", exp_wr.size(), exp_dump.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
